mem_port_arbiter: RTL

//  Shares the single unified byte-addressed memory between the fetch port (32-bit instruction reads)
//  and the load/store port (64-bit data reads/writes) of tinker_core. Serialises accesses, holds

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
// Ports: none (bundle only). Modport slave is the arbiter's view; modport master is the
// combined requester/memory view used by whoever surrounds the arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        ds_req;
  logic        ds_we;
  logic [63:0] ds_addr;
  logic [63:0] ds_wdata;
  logic        ds_gnt;
  logic [63:0] ds_rdata;
  logic [63:0] mem_addr;
  logic        mem_rd_instr;
  logic        mem_rd_data;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [31:0] mem_instr;
  logic [63:0] mem_data;
  logic        busy;
  modport slave (
    input  if_req, if_addr, ds_req, ds_we, ds_addr, ds_wdata, mem_instr, mem_data,
    output if_gnt, if_rdata, ds_gnt, ds_rdata, mem_addr, mem_rd_instr, mem_rd_data,
           mem_we, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, ds_req, ds_we, ds_addr, ds_wdata, mem_instr, mem_data,
    input  if_gnt, if_rdata, ds_gnt, ds_rdata, mem_addr, mem_rd_instr, mem_rd_data,
           mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store accesses onto one memory, MEM_LAT cycles each
// Ports: clk, reset (async, active-high), bus (mem_port_arbiter_if.slave: fetch port,
// load/store port, memory port, busy). Optional macro ARB_STARVE_GUARD_EN lets a waiting
// fetch win after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  if (MEM_LAT < 1 || STARVE_MAX < 0) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT must be >= 1 and STARVE_MAX >= 0");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic          data_q, data_d, we_q, we_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d, ds_rdata_q, ds_rdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_data, accept, in_busy;
  assign accept  = state_q == IDLE && (bus.if_req || bus.ds_req);
  assign in_busy = state_q == BUSY;
`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [SW-1:0] starve_q, starve_d;
  // Data normally wins; a fetch that has watched STARVE_MAX data grants go by takes the slot.
  assign pick_data = bus.ds_req && !(bus.if_req && starve_q == SW'(STARVE_MAX));
  always_comb begin
    starve_d = starve_q;
    if (accept) starve_d = (pick_data && bus.if_req) ? starve_q + SW'(1) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
`else
  assign pick_data = bus.ds_req;
`endif
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    ds_rdata_d = ds_rdata_q;
    if (accept) begin
      state_d = BUSY;
      data_d  = pick_data;
      we_d    = pick_data && bus.ds_we;
      addr_d  = pick_data ? bus.ds_addr : bus.if_addr;
      wdata_d = bus.ds_wdata;
      cnt_d   = CW'(MEM_LAT - 1);
    end else if (in_busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d    = DONE;
        if_rdata_d = !data_q ? bus.mem_instr : if_rdata_q;
        ds_rdata_d = (data_q && !we_q) ? bus.mem_data : ds_rdata_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      ds_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ds_rdata_q <= ds_rdata_d;
    end
  // Memory is driven only while BUSY; the write strobe marks the first BUSY cycle only.
  assign bus.mem_addr     = in_busy ? addr_q : '0;
  assign bus.mem_rd_instr = in_busy && !data_q;
  assign bus.mem_rd_data  = in_busy && data_q && !we_q;
  assign bus.mem_we       = in_busy && we_q && cnt_q == CW'(MEM_LAT - 1);
  assign bus.mem_wdata    = (in_busy && we_q) ? wdata_q : '0;
  assign bus.if_gnt       = state_q == DONE && !data_q;
  assign bus.ds_gnt       = state_q == DONE && data_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.ds_rdata     = ds_rdata_q;
  assign bus.busy         = state_q != IDLE;
endmodule
